// File: rtl/soc.sv
// soc: multi-cycle RV32I core, 4 KiB unified RAM, LED register and 8N1 UART
// transmitter on one memory-mapped bus. The UART exists only when SOC_UART_EN is defined.
module soc #(
  parameter string ROM_FILE = "rom.hex",
  parameter int    UART_DIV = 217
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] led,
  output logic       uart_tx
);
  localparam logic [31:0] LED_ADDR  = 32'h8000_0000;
  localparam logic [31:0] UART_ADDR = 32'h8000_0004;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_LOAD} cpu_state_t;

  logic [31:0] mem  [0:1023];
  logic [31:0] regs [0:31];
  cpu_state_t  cpu_state;
  logic [31:0] pc, pc_next, rdata, io_rdata;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_rd, uart_busy;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0:    alu = alt ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'b0, sa < sb};
      3'd3:    alu = {31'b0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? $unsigned(sa >>> b[4:0]) : a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0:    br_taken = (a == b);
      3'd1:    br_taken = (a != b);
      3'd4:    br_taken = (sa < sb);
      3'd5:    br_taken = (sa >= sb);
      3'd6:    br_taken = (a < b);
      3'd7:    br_taken = (a >= b);
      default: br_taken = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'd0:    load_ext = {{24{sh[7]}}, sh[7:0]};
      3'd1:    load_ext = {{16{sh[15]}}, sh[15:0]};
      3'd4:    load_ext = {24'b0, sh[7:0]};
      3'd5:    load_ext = {16'b0, sh[15:0]};
      default: load_ext = sh;
    endcase
  endfunction

  // In EXEC the read-data register still holds the fetched instruction.
  logic [31:0] ins, imm_i, imm_s, imm_b, imm_u, imm_j, rv1, rv2, alu_b, ea, wb_val;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [4:0]  wb_idx;
  logic [3:0]  st_mask;
  logic        alt, wb_en;

  assign ins   = rdata;
  assign opc   = ins[6:0];
  assign f3    = ins[14:12];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign rv1   = (ins[19:15] == 5'd0) ? 32'd0 : regs[ins[19:15]];
  assign rv2   = (ins[24:20] == 5'd0) ? 32'd0 : regs[ins[24:20]];
  assign alu_b = (opc == OP_REG) ? rv2 : imm_i;
  assign alt   = ins[30] && ((opc == OP_REG) || (f3 == 3'd5));
  assign ea    = rv1 + ((opc == OP_ST) ? imm_s : imm_i);
  assign st_mask   = (f3[1:0] == 2'd0) ? 4'b0001 : (f3[1:0] == 2'd1) ? 4'b0011 : 4'b1111;
  assign bus_wdata = rv2 << {ea[1:0], 3'b000};

  always_comb begin
    pc_next   = pc + 32'd4;
    wb_en     = 1'b0;
    wb_idx    = ins[11:7];
    wb_val    = alu(rv1, alu_b, f3, alt);
    bus_addr  = pc;
    bus_rd    = 1'b0;
    bus_wstrb = 4'b0000;
    case (cpu_state)
      S_FETCH: bus_rd = 1'b1;
      S_EXEC: begin
        case (opc)
          OP_LUI:   begin wb_en = 1'b1; wb_val = imm_u; end
          OP_AUIPC: begin wb_en = 1'b1; wb_val = pc + imm_u; end
          OP_JAL:   begin wb_en = 1'b1; wb_val = pc + 32'd4; pc_next = pc + imm_j; end
          OP_JALR:  begin wb_en = 1'b1; wb_val = pc + 32'd4; pc_next = (rv1 + imm_i) & ~32'd1; end
          OP_BR:    if (br_taken(rv1, rv2, f3)) pc_next = pc + imm_b;
          OP_LD:    begin bus_addr = ea; bus_rd = 1'b1; end
          OP_ST:    begin bus_addr = ea; bus_wstrb = st_mask << ea[1:0]; end
          OP_IMM, OP_REG: wb_en = 1'b1;
          default: ;
        endcase
      end
      S_LOAD: begin
        wb_en  = 1'b1;
        wb_idx = ld_rd;
        wb_val = load_ext(rdata, ld_off, ld_f3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_state <= S_FETCH;
      pc        <= '0;
    end else begin
      case (cpu_state)
        S_FETCH: cpu_state <= S_EXEC;
        S_EXEC: begin
          pc        <= pc_next;
          cpu_state <= (opc == OP_LD) ? S_LOAD : S_FETCH;
        end
        default: cpu_state <= S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wb_en && (wb_idx != 5'd0)) regs[wb_idx] <= wb_val;
    if (cpu_state == S_EXEC) begin
      ld_rd  <= ins[11:7];
      ld_f3  <= f3;
      ld_off <= ea[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!bus_addr[31])
      for (int b = 0; b < 4; b++)
        if (bus_wstrb[b]) mem[bus_addr[11:2]][8*b +: 8] <= bus_wdata[8*b +: 8];
  end

  always_comb begin
    io_rdata = '0;
    if (bus_addr == LED_ADDR)       io_rdata = {24'b0, led};
    else if (bus_addr == UART_ADDR) io_rdata = {31'b0, uart_busy};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
      led   <= '0;
    end else begin
      if (bus_rd) rdata <= bus_addr[31] ? io_rdata : mem[bus_addr[11:2]];
      if ((bus_addr == LED_ADDR) && bus_wstrb[0]) led <= bus_wdata[7:0];
    end
  end

`ifdef SOC_UART_EN
  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

  uart_state_t u_state;
  logic [15:0] u_cnt;
  logic [2:0]  u_bit;
  logic [7:0]  u_shift;
  logic        u_last, uart_we;

  assign uart_busy = (u_state != U_IDLE);
  assign u_last    = (u_cnt == 16'(UART_DIV - 1));
  assign uart_we   = (bus_addr == UART_ADDR) && bus_wstrb[0] && !uart_busy;

  always_ff @(posedge clk) begin
    if (uart_we)                       u_shift <= bus_wdata[7:0];
    else if ((u_state == U_DATA) && u_last) u_shift <= u_shift >> 1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_state <= U_IDLE;
      u_cnt   <= '0;
      u_bit   <= '0;
      uart_tx <= 1'b1;
    end else begin
      u_cnt <= u_last ? 16'd0 : u_cnt + 16'd1;
      case (u_state)
        U_IDLE: begin
          u_cnt <= '0;
          if (uart_we) begin
            u_state <= U_START;
            uart_tx <= 1'b0;
          end
        end
        U_START: if (u_last) begin
          u_state <= U_DATA;
          u_bit   <= '0;
          uart_tx <= u_shift[0];
        end
        U_DATA: if (u_last) begin
          if (u_bit == 3'd7) begin
            u_state <= U_STOP;
            uart_tx <= 1'b1;
          end else begin
            u_bit   <= u_bit + 3'd1;
            uart_tx <= u_shift[1];
          end
        end
        default: if (u_last) u_state <= U_IDLE;
      endcase
    end
  end
`else
  assign uart_busy = 1'b0;
  assign uart_tx   = 1'b1;
`endif

endmodule

// File: tb/tb_soc.sv
// Scoreboard bench for soc: loads a small RV32I program, checks LED writes and
// UART frames against queued expectations, then aborts a frame with reset and reruns.
module tb_soc;
  localparam int DIV = 4;
`ifdef SOC_UART_EN
  localparam bit UART_ON = 1'b1;
`else
  localparam bit UART_ON = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] led;
  logic       uart_tx;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  logic [7:0]  led_q  [$];
  logic [7:0]  uart_q [$];
  logic [31:0] prog   [$];

  soc #(.ROM_FILE(""), .UART_DIV(DIV)) dut (
    .clk(clk),
    .reset(reset),
    .led(led),
    .uart_tx(uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic push_expectations(input bit with_f0);
    logic [7:0] stat;
    stat = UART_ON ? 8'h01 : 8'h00;
    led_q = '{8'h30, 8'hA5, 8'hA6, 8'h44, 8'hEE, 8'h22, 8'h11, 8'hFF, stat, 8'h5A};
    uart_q.delete();
    if (UART_ON) begin
      uart_q.push_back(8'h55);
      if (with_f0) uart_q.push_back(8'hF0);
    end
  endtask

  // LED monitor: every bus write to the LED register must show on led one cycle later.
  initial begin : led_mon
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!reset && (dut.bus_addr == 32'h8000_0000) && dut.bus_wstrb[0]) begin
        @(negedge clk);
        if (led_q.size() == 0) check("led_unexpected_write", led_q.size(), 1);
        else begin
          e = led_q.pop_front();
          check("led_value", {24'b0, led}, {24'b0, e});
        end
      end
    end
  end

  // UART monitor: a falling line starts a frame checked cycle by cycle.
  initial begin : uart_mon
    logic [7:0] b;
    logic       exp_bit;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && (uart_tx == 1'b0)) begin
        if (uart_q.size() == 0) begin
          check("uart_unexpected_frame", uart_q.size(), 1);
          for (int i = 0; i < 20 * DIV && uart_tx == 1'b0; i++) @(negedge clk);
        end else begin
          b = uart_q.pop_front();
          for (int k = 0; k < 10 * DIV; k++) begin
            if (k < DIV)           exp_bit = 1'b0;
            else if (k >= 9 * DIV) exp_bit = 1'b1;
            else                   exp_bit = b[(k / DIV) - 1];
            check("uart_bit", {31'b0, uart_tx}, {31'b0, exp_bit});
            if (k < 10 * DIV - 1) @(negedge clk);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b1;
    prog = '{
      enc_u(20'h80000, 5'd1, 7'h37),
      enc_i(12'h004, 5'd1, 3'd2, 5'd9, 7'h03),
      enc_i(12'h030, 5'd9, 3'd0, 5'd9, 7'h13),
      enc_s(12'h000, 5'd9, 5'd1, 3'd0),
      enc_i(12'h0A5, 5'd0, 3'd0, 5'd2, 7'h13),
      enc_s(12'h000, 5'd2, 5'd1, 3'd0),
      enc_i(12'h000, 5'd1, 3'd2, 5'd3, 7'h03),
      enc_i(12'h001, 5'd3, 3'd0, 5'd3, 7'h13),
      enc_s(12'h000, 5'd3, 5'd1, 3'd0),
      enc_u(20'h11223, 5'd4, 7'h37),
      enc_i(12'h344, 5'd4, 3'd0, 5'd4, 7'h13),
      enc_s(12'h100, 5'd4, 5'd0, 3'd2),
      enc_i(12'h0EE, 5'd0, 3'd0, 5'd5, 7'h13),
      enc_s(12'h101, 5'd5, 5'd0, 3'd0),
      enc_i(12'h100, 5'd0, 3'd2, 5'd6, 7'h03),
      enc_s(12'h000, 5'd6, 5'd1, 3'd0),
      enc_i(12'h008, 5'd6, 3'd5, 5'd7, 7'h13),
      enc_s(12'h000, 5'd7, 5'd1, 3'd0),
      enc_i(12'h010, 5'd6, 3'd5, 5'd7, 7'h13),
      enc_s(12'h000, 5'd7, 5'd1, 3'd0),
      enc_i(12'h018, 5'd6, 3'd5, 5'd7, 7'h13),
      enc_s(12'h000, 5'd7, 5'd1, 3'd0),
      enc_i(12'h101, 5'd0, 3'd0, 5'd8, 7'h03),
      enc_i(12'h018, 5'd8, 3'd5, 5'd8, 7'h13),
      enc_s(12'h000, 5'd8, 5'd1, 3'd0),
      enc_i(12'h055, 5'd0, 3'd0, 5'd2, 7'h13),
      enc_s(12'h004, 5'd2, 5'd1, 3'd2),
      enc_i(12'h004, 5'd1, 3'd2, 5'd9, 7'h03),
      enc_s(12'h000, 5'd9, 5'd1, 3'd0),
      enc_i(12'h033, 5'd0, 3'd0, 5'd2, 7'h13),
      enc_s(12'h004, 5'd2, 5'd1, 3'd2),
      enc_i(12'h004, 5'd1, 3'd2, 5'd9, 7'h03),
      enc_b(13'h1FFC, 5'd0, 5'd9, 3'd1),
      enc_i(12'h05A, 5'd9, 3'd0, 5'd9, 7'h13),
      enc_s(12'h000, 5'd9, 5'd1, 3'd0),
      enc_i(12'h0F0, 5'd0, 3'd0, 5'd2, 7'h13),
      enc_s(12'h004, 5'd2, 5'd1, 3'd2),
      enc_j(21'd0, 5'd0)
    };
    for (int i = 0; i < 1024; i++) dut.mem[i] <= (i < prog.size()) ? prog[i] : 32'd0;
    push_expectations(1'b0);

    repeat (5) begin
      @(negedge clk);
      check("reset_led", {24'b0, led}, 32'h0);
      check("reset_tx", {31'b0, uart_tx}, 32'h1);
    end
    reset = 1'b0;
    #1;
    check("first_fetch_rd", {31'b0, dut.bus_rd}, 32'h1);
    check("first_fetch_addr", dut.bus_addr, 32'h0);
    mon_en = 1'b1;

    for (int i = 0; i < 3000 && led_q.size() != 0; i++) @(negedge clk);
    check("run1_led_done", led_q.size(), 0);
    check("run1_uart_done", uart_q.size(), 0);
    mon_en = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = (dut.bus_addr == 32'h8000_0004) && dut.bus_wstrb[0] && (dut.bus_wdata[7:0] == 8'hF0);
    end
    check("f0_store_seen", {31'b0, found}, 32'h1);
    repeat (2 * DIV + 2) @(negedge clk);
    check("tx_mid_bit1", {31'b0, uart_tx}, UART_ON ? 32'h0 : 32'h1);
    #2 reset = 1'b1;
    #1;
    check("tx_async_reset", {31'b0, uart_tx}, 32'h1);
    check("led_async_reset", {24'b0, led}, 32'h0);
    push_expectations(1'b1);
    repeat (5) begin
      @(negedge clk);
      check("reset2_tx", {31'b0, uart_tx}, 32'h1);
    end
    reset = 1'b0;
    #1;
    check("refetch_rd", {31'b0, dut.bus_rd}, 32'h1);
    check("refetch_addr", dut.bus_addr, 32'h0);
    mon_en = 1'b1;

    for (int i = 0; i < 3000 && (led_q.size() != 0 || uart_q.size() != 0); i++) @(negedge clk);
    repeat (10 * DIV + 10) @(negedge clk);
    check("run2_led_done", led_q.size(), 0);
    check("run2_uart_done", uart_q.size(), 0);
    check("idle_tx", {31'b0, uart_tx}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
